// File: rtl/slave_out_pkg.sv
// Shared definitions for the system bus serial read path.
// Holds the transmitter state encoding and the default word / burst-count
// widths used by both this slave transmitter and the master receiver.
package slave_out_pkg;

  localparam int DATA_LEN_DEF  = 8;
  localparam int BURST_LEN_DEF = 12;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_DONE  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/slave_out_tx_word_buffer.sv
// tx_word_buffer: one-entry holding register for the next word of a burst.
// Ports:
//   clk, reset    clock, synchronous active-high reset (clears full only)
//   flush         drop any held word (start of burst / abort)
//   push          write data_in; only issued while empty
//   pop           consume the held word; only issued while full
//   data_in       word to hold
//   data_out      held word
//   full          a word is held
//   full_next     value full takes at the next edge, so the owner can
//                 register decodes that depend on it
module tx_word_buffer
  import slave_out_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                push,
  input  logic                pop,
  input  logic [DATA_LEN-1:0] data_in,
  output logic [DATA_LEN-1:0] data_out,
  output logic                full,
  output logic                full_next
);

  logic [DATA_LEN-1:0] data_q;

  always_comb begin
    full_next = full;
    if (flush) begin
      full_next = 1'b0;
    end else if (push) begin
      full_next = 1'b1;
    end else if (pop) begin
      full_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full <= 1'b0;
    end else begin
      full <= full_next;
    end
  end

  // Data path register carries no reset; full qualifies it.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      data_q <= data_in;
    end
  end

  assign data_out = data_q;

endmodule

// File: rtl/slave_out.sv
// slave_out: slave-side serial transmitter for the bus read path.
// Fetches DATA_LEN-bit words over a ready/valid port and shifts them out
// LSB-first on tx_data/slave_valid, burst_num+1 words per request, paced by
// master_ready. Dropping approval_grant mid-transfer aborts without tx_done.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   start, burst_num   read request and word count minus one
//   approval_grant     arbiter grant, must stay high for the transfer
//   master_ready       master accepts a bit this cycle
//   word_in/valid      parallel word from slave storage
//   word_ready         word request to storage
//   slave_valid        tx_data carries a bit
//   tx_data            serial data, LSB first
//   tx_done            one-cycle pulse after the last bit
//   busy               transfer in progress
// All outputs are registered from next-state values.
module slave_out
  import slave_out_pkg::*;
#(
  parameter int DATA_LEN  = DATA_LEN_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [BURST_LEN-1:0] burst_num,
  input  logic                 approval_grant,
  input  logic                 master_ready,
  input  logic [DATA_LEN-1:0]  word_in,
  input  logic                 word_valid,
  output logic                 word_ready,
  output logic                 slave_valid,
  output logic                 tx_data,
  output logic                 tx_done,
  output logic                 busy
);

  // Word counters are one bit wider than burst_num so a full 2^BURST_LEN
  // burst is representable.
  localparam int CW = BURST_LEN + 1;
  localparam int BW = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_LEN - 1);

  tx_state_t             state_q, state_d;
  logic [DATA_LEN-1:0]   shift_q, shift_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [CW-1:0]         fetched_q, fetched_d;
  logic [CW-1:0]         sent_q, sent_d;
  logic [BURST_LEN-1:0]  burst_q, burst_d;
  logic [CW-1:0]         total_q, total_d;

  logic                  buf_push, buf_pop, buf_flush;
  logic                  buf_full, buf_full_d;
  logic [DATA_LEN-1:0]   buf_data;

  logic                  take, beat, eow, last_word, ready_d;

  tx_word_buffer #(
    .DATA_LEN (DATA_LEN)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (buf_flush),
    .push      (buf_push),
    .pop       (buf_pop),
    .data_in   (word_in),
    .data_out  (buf_data),
    .full      (buf_full),
    .full_next (buf_full_d)
  );

  // Grant is folded into the handshake so a word offered on the abort
  // cycle is never taken.
  assign take      = word_ready & word_valid & approval_grant;
  assign beat      = slave_valid & master_ready;
  assign eow       = (bit_q == LAST_BIT);
  assign total_q   = {1'b0, burst_q} + CW'(1);
  assign total_d   = {1'b0, burst_d} + CW'(1);
  assign last_word = ((sent_q + CW'(1)) == total_q);

  // ---- next-state / datapath decode ----
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    fetched_d = fetched_q;
    sent_d    = sent_q;
    burst_d   = burst_q;
    buf_push  = 1'b0;
    buf_pop   = 1'b0;
    buf_flush = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && approval_grant) begin
          burst_d   = burst_num;
          fetched_d = '0;
          sent_d    = '0;
          bit_d     = '0;
          buf_flush = 1'b1;
          state_d   = S_FETCH;
        end
      end

      S_FETCH: begin
        if (!approval_grant) begin
          fetched_d = '0;
          sent_d    = '0;
          bit_d     = '0;
          buf_flush = 1'b1;
          state_d   = S_IDLE;
        end else if (take) begin
          shift_d   = word_in;
          bit_d     = '0;
          fetched_d = fetched_q + CW'(1);
          state_d   = S_SEND;
        end
      end

      S_SEND: begin
        if (!approval_grant) begin
          fetched_d = '0;
          sent_d    = '0;
          bit_d     = '0;
          buf_flush = 1'b1;
          state_d   = S_IDLE;
        end else begin
          if (take) begin
            fetched_d = fetched_q + CW'(1);
            buf_push  = 1'b1;
          end
          if (beat) begin
            if (eow) begin
              bit_d  = '0;
              sent_d = sent_q + CW'(1);
              if (last_word) begin
                state_d = S_DONE;
              end else if (buf_full) begin
                shift_d = buf_data;
                buf_pop = 1'b1;
              end else if (take) begin
                // Word arrives on the very edge the current one ends:
                // bypass the buffer instead of stalling through FETCH.
                shift_d  = word_in;
                buf_push = 1'b0;
              end else begin
                state_d = S_FETCH;
              end
            end else begin
              shift_d = shift_q >> 1;
              bit_d   = bit_q + BW'(1);
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ready_d = (state_d == S_FETCH) ||
                   ((state_d == S_SEND) && !buf_full_d && (fetched_d < total_d));

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- counters and registered outputs ----
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_q       <= '0;
      fetched_q   <= '0;
      sent_q      <= '0;
      burst_q     <= '0;
      word_ready  <= 1'b0;
      slave_valid <= 1'b0;
      tx_data     <= 1'b0;
      tx_done     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      bit_q       <= bit_d;
      fetched_q   <= fetched_d;
      sent_q      <= sent_d;
      burst_q     <= burst_d;
      word_ready  <= ready_d;
      slave_valid <= (state_d == S_SEND);
      tx_data     <= (state_d == S_SEND) ? shift_d[0] : 1'b0;
      tx_done     <= (state_d == S_DONE);
      busy        <= (state_d == S_FETCH) || (state_d == S_SEND);
    end
  end

  // ---- shift register (data, no reset) ----
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

endmodule

// File: tb/tb_slave_out.sv
module tb_slave_out;
  import slave_out_pkg::*;

  localparam int DL = 8;
  localparam int BL = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [BL-1:0] burst_num;
  logic          approval_grant;
  logic          master_ready;
  logic [DL-1:0] word_in;
  logic          word_valid;
  logic          word_ready;
  logic          slave_valid;
  logic          tx_data;
  logic          tx_done;
  logic          busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int xfer_cnt = 0;
  int beat_cnt = 0;

  bit            exp_q[$];
  logic [DL-1:0] src_q[$];
  bit            hold_src = 1'b0;

  slave_out #(
    .DATA_LEN  (DL),
    .BURST_LEN (BL)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .burst_num      (burst_num),
    .approval_grant (approval_grant),
    .master_ready   (master_ready),
    .word_in        (word_in),
    .word_valid     (word_valid),
    .word_ready     (word_ready),
    .slave_valid    (slave_valid),
    .tx_data        (tx_data),
    .tx_done        (tx_done),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Scoreboard: accepted words push their bits LSB-first; each beat pops one.
  always @(negedge clk) begin
    bit e;
    if (reset === 1'b0) begin
      if (slave_valid && master_ready && approval_grant) begin
        beat_cnt++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL bit_stream: beat with tx_data=%0b but no bit expected", tx_data);
        end else begin
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            n_fail++;
            $display("FAIL bit_stream: tx_data=%0b expected %0b at %0t", tx_data, e, $time);
          end
        end
      end
      if (word_ready && word_valid && approval_grant) begin
        xfer_cnt++;
        for (int i = 0; i < DL; i++) exp_q.push_back(word_in[i]);
        if (src_q.size() != 0) void'(src_q.pop_front());
      end
      if (tx_done === 1'b1) done_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_src();
    word_valid = (src_q.size() != 0) && !hold_src;
    word_in    = (src_q.size() != 0) ? src_q[0] : '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive_src();
  endtask

  task automatic run_until_done(input int budget, output int vcyc, output int gaps, output bit to);
    vcyc = 0;
    gaps = 0;
    to   = 1'b1;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (tx_done === 1'b1) begin
        to = 1'b0;
        break;
      end
      if (slave_valid === 1'b1) vcyc++;
      else if (vcyc > 0) gaps++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; burst_num = '0; approval_grant = 1'b1;
    master_ready = 1'b1; src_q.delete(); drive_src();
    tick(); tick();
    n_cmp++; if (slave_valid !== 1'b0) begin n_fail++; $display("FAIL reset_slave_valid: got %b want 0", slave_valid); end
    n_cmp++; if (tx_data !== 1'b0) begin n_fail++; $display("FAIL reset_tx_data: got %b want 0", tx_data); end
    n_cmp++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL reset_tx_done: got %b want 0", tx_done); end
    n_cmp++; if (word_ready !== 1'b0) begin n_fail++; $display("FAIL reset_word_ready: got %b want 0", word_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0;
    tick();
    // start without grant is ignored
    approval_grant = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; approval_grant = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nogrant_busy: got %b want 0", busy); end
    n_cmp++; if (word_ready !== 1'b0) begin n_fail++; $display("FAIL nogrant_word_ready: got %b want 0", word_ready); end
  endtask

  task automatic test_single();
    int v, g, bd, bx, bb;
    bit to;
    bd = done_cnt; bx = xfer_cnt; bb = beat_cnt;
    exp_q.delete();
    src_q.push_back(8'hA5);
    burst_num = 12'd0; master_ready = 1'b1;
    start = 1'b1; drive_src();
    tick();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_n1: got %b want 1", busy); end
    n_cmp++; if (word_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_n1: got %b want 1", word_ready); end
    n_cmp++; if (slave_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_n1: got %b want 0", slave_valid); end
    tick();
    n_cmp++; if (slave_valid !== 1'b1 || tx_data !== 1'b1) begin n_fail++; $display("FAIL single_first_bit: valid=%b data=%b want 1/1", slave_valid, tx_data); end
    run_until_done(40, v, g, to);
    v = v + 1;
    n_cmp++; if (to) begin n_fail++; $display("FAIL single_timeout: no tx_done within 40 cycles"); end
    n_cmp++; if (v != 8 || g != 0) begin n_fail++; $display("FAIL single_valid_cycles: got %0d valid %0d gaps want 8/0", v, g); end
    tick();
    n_cmp++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse: tx_done=%b want 0 after one cycle", tx_done); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", busy); end
    n_cmp++; if (done_cnt - bd != 1) begin n_fail++; $display("FAIL single_done_count: got %0d want 1", done_cnt - bd); end
    n_cmp++; if (xfer_cnt - bx != 1) begin n_fail++; $display("FAIL single_xfer_count: got %0d want 1", xfer_cnt - bx); end
    n_cmp++; if (beat_cnt - bb != 8) begin n_fail++; $display("FAIL single_beats: got %0d want 8", beat_cnt - bb); end
  endtask

  task automatic test_burst();
    int v, g, bd, bx, bb;
    bit to;
    bd = done_cnt; bx = xfer_cnt; bb = beat_cnt;
    exp_q.delete();
    src_q.push_back(8'h01); src_q.push_back(8'h80); src_q.push_back(8'hFF);
    burst_num = 12'd2; master_ready = 1'b1;
    start = 1'b1; drive_src();
    tick();
    start = 1'b0;
    run_until_done(80, v, g, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL burst_timeout: no tx_done within 80 cycles"); end
    n_cmp++; if (v != 24 || g != 0) begin n_fail++; $display("FAIL burst_contiguous: got %0d valid %0d gaps want 24/0", v, g); end
    tick();
    n_cmp++; if (xfer_cnt - bx != 3) begin n_fail++; $display("FAIL burst_xfers: got %0d want 3", xfer_cnt - bx); end
    n_cmp++; if (done_cnt - bd != 1) begin n_fail++; $display("FAIL burst_done_count: got %0d want 1", done_cnt - bd); end
    n_cmp++; if (beat_cnt - bb != 24) begin n_fail++; $display("FAIL burst_beats: got %0d want 24", beat_cnt - bb); end
  endtask

  task automatic test_backpressure();
    int v, g, bd, bb;
    bit to;
    logic [DL-1:0] w;
    w = 8'h3C;
    bd = done_cnt; bb = beat_cnt;
    exp_q.delete();
    src_q.push_back(w);
    burst_num = 12'd0; master_ready = 1'b1;
    start = 1'b1; drive_src();
    tick();
    start = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) tick();
    master_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (slave_valid !== 1'b1 || tx_data !== w[4]) begin
        n_fail++;
        $display("FAIL backpressure_hold: cycle %0d valid=%b data=%b want 1/%b", k, slave_valid, tx_data, w[4]);
      end
    end
    master_ready = 1'b1;
    run_until_done(40, v, g, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL backpressure_timeout: no tx_done"); end
    tick();
    n_cmp++; if (beat_cnt - bb != 8) begin n_fail++; $display("FAIL backpressure_beats: got %0d want 8", beat_cnt - bb); end
    n_cmp++; if (done_cnt - bd != 1) begin n_fail++; $display("FAIL backpressure_done: got %0d want 1", done_cnt - bd); end
  endtask

  task automatic test_underrun();
    int v, g, bd, bx, bb;
    bit to, seen, fell;
    bd = done_cnt; bx = xfer_cnt; bb = beat_cnt;
    exp_q.delete();
    src_q.push_back(8'h5A);
    burst_num = 12'd1; master_ready = 1'b1;
    start = 1'b1; drive_src();
    tick();
    start = 1'b0;
    seen = 1'b0; fell = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (slave_valid === 1'b1) seen = 1'b1;
      else if (seen) begin fell = 1'b1; break; end
    end
    n_cmp++; if (!fell) begin n_fail++; $display("FAIL underrun_gap_start: slave_valid never dropped after word 1"); end
    n_cmp++; if (word_ready !== 1'b1) begin n_fail++; $display("FAIL underrun_ready: got %b want 1", word_ready); end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if (slave_valid !== 1'b0) begin n_fail++; $display("FAIL underrun_gap: cycle %0d slave_valid=%b want 0", k, slave_valid); end
    end
    src_q.push_back(8'hC3);
    drive_src();
    run_until_done(40, v, g, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL underrun_timeout: no tx_done"); end
    n_cmp++; if (v != 8 || g != 0) begin n_fail++; $display("FAIL underrun_word2: got %0d valid %0d gaps want 8/0", v, g); end
    tick();
    n_cmp++; if (xfer_cnt - bx != 2) begin n_fail++; $display("FAIL underrun_xfers: got %0d want 2", xfer_cnt - bx); end
    n_cmp++; if (beat_cnt - bb != 16) begin n_fail++; $display("FAIL underrun_beats: got %0d want 16", beat_cnt - bb); end
    n_cmp++; if (done_cnt - bd != 1) begin n_fail++; $display("FAIL underrun_done: got %0d want 1", done_cnt - bd); end
  endtask

  task automatic test_abort();
    int v, g, bd;
    bit to;
    bd = done_cnt;
    exp_q.delete();
    src_q.push_back(8'h96); src_q.push_back(8'h69);
    burst_num = 12'd1; master_ready = 1'b1;
    start = 1'b1; drive_src();
    tick();
    start = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) tick();
    approval_grant = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_cmp++; if (slave_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b want 0", slave_valid); end
    n_cmp++; if (word_ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready: got %b want 0", word_ready); end
    approval_grant = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    n_cmp++; if (done_cnt != bd) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt - bd); end
    exp_q.delete(); src_q.delete(); drive_src();
    src_q.push_back(8'hE7);
    burst_num = 12'd0;
    start = 1'b1; drive_src();
    tick();
    start = 1'b0;
    run_until_done(40, v, g, to);
    n_cmp++; if (to || v != 8 || g != 0) begin n_fail++; $display("FAIL abort_restart: timeout=%b valid=%0d gaps=%0d want 0/8/0", to, v, g); end
    tick();
    n_cmp++; if (done_cnt - bd != 1) begin n_fail++; $display("FAIL abort_restart_done: got %0d want 1", done_cnt - bd); end
  endtask

  task automatic test_reset_mid();
    int v, g, bd, bx;
    bit to;
    bd = done_cnt;
    exp_q.delete();
    src_q.push_back(8'h11); src_q.push_back(8'h22); src_q.push_back(8'h33);
    burst_num = 12'd2; master_ready = 1'b1;
    start = 1'b1; drive_src();
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    burst_num = 12'd0; start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1 || slave_valid !== 1'b1) begin n_fail++; $display("FAIL busy_start_ignored: busy=%b valid=%b want 1/1", busy, slave_valid); end
    for (int k = 0; k < 6; k++) tick();
    reset = 1'b1;
    tick();
    n_cmp++; if (slave_valid !== 1'b0 || tx_data !== 1'b0) begin n_fail++; $display("FAIL midreset_serial: valid=%b data=%b want 0/0", slave_valid, tx_data); end
    n_cmp++; if (busy !== 1'b0 || word_ready !== 1'b0 || tx_done !== 1'b0) begin n_fail++; $display("FAIL midreset_ctrl: busy=%b ready=%b done=%b want 0/0/0", busy, word_ready, tx_done); end
    reset = 1'b0;
    exp_q.delete(); src_q.delete(); drive_src();
    tick(); tick();
    n_cmp++; if (done_cnt != bd) begin n_fail++; $display("FAIL midreset_no_done: got %0d pulses want 0", done_cnt - bd); end
    bx = xfer_cnt;
    src_q.push_back(8'h12); src_q.push_back(8'h34);
    burst_num = 12'd1;
    start = 1'b1; drive_src();
    tick();
    start = 1'b0;
    run_until_done(60, v, g, to);
    n_cmp++; if (to || v != 16 || g != 0) begin n_fail++; $display("FAIL midreset_clean: timeout=%b valid=%0d gaps=%0d want 0/16/0", to, v, g); end
    tick();
    n_cmp++; if (xfer_cnt - bx != 2) begin n_fail++; $display("FAIL midreset_xfers: got %0d want 2", xfer_cnt - bx); end
    n_cmp++; if (done_cnt - bd != 1) begin n_fail++; $display("FAIL midreset_done: got %0d want 1", done_cnt - bd); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; burst_num = '0; approval_grant = 1'b1;
    master_ready = 1'b1; word_in = '0; word_valid = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_underrun();
    test_abort();
    test_reset_mid();
    tick(); tick();
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL leftover_bits: %0d bits never sent", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
